reg_write_arbiter: RTL and testbench

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 168 ++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Register-file write port arbiter: merges non-stallable load returns with
// buffered ALU results and keeps a per-register busy scoreboard.
module reg_write_arbiter #(
    parameter int WORD_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_NUM        = 32
) (
    input  logic                      gclk,
    input  logic                      PowerOn_n,

    input  logic                      IssueValid,
    input  logic [REG_ADDR_WIDTH-1:0] IssueAddr,

    input  logic                      AluValid,
    input  logic [REG_ADDR_WIDTH-1:0] AluAddr,
    input  logic [WORD_WIDTH-1:0]     AluData,
    output logic                      AluReady,

    input  logic                      LdValid,
    input  logic [REG_ADDR_WIDTH-1:0] LdAddr,
    input  logic [WORD_WIDTH-1:0]     LdData,

    input  logic [REG_ADDR_WIDTH-1:0] AddrReadA,
    input  logic [REG_ADDR_WIDTH-1:0] AddrReadB,
    input  logic [REG_ADDR_WIDTH-1:0] AddrReadC,
    output logic                      BusyA,
    output logic                      BusyB,
    output logic                      BusyC,

    output logic                      WriteFlag,
    output logic [REG_ADDR_WIDTH-1:0] AddrWrite,
    output logic [WORD_WIDTH-1:0]     Write,
    output logic                      OverflowErr
);

    // ALU handshake: a result transfers on a cycle where AluValid and AluReady
    // are both high; AluReady depends only on FIFO occupancy. Loads have no
    // handshake and always win the write port.

    logic [REG_ADDR_WIDTH-1:0] fifo_addr_q [2];
    logic [REG_ADDR_WIDTH-1:0] fifo_addr_d [2];
    logic [WORD_WIDTH-1:0]     fifo_data_q [2];
    logic [WORD_WIDTH-1:0]     fifo_data_d [2];
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;

    logic                      write_flag_q, write_flag_d;
    logic [REG_ADDR_WIDTH-1:0] write_addr_q, write_addr_d;
    logic [WORD_WIDTH-1:0]     write_data_q, write_data_d;

    logic [REG_NUM-1:0]        busy_q, busy_d;
    logic                      overflow_q, overflow_d;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      alu_accept;
    logic                      sel_valid;
    logic [REG_ADDR_WIDTH-1:0] sel_addr;
    logic [WORD_WIDTH-1:0]     sel_data;
    logic                      pop;
    logic                      push;
    logic                      bypass;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);
    assign AluReady   = !fifo_full;
    assign alu_accept = AluValid && !fifo_full;

    always_comb begin
        sel_valid = 1'b0;
        sel_addr  = write_addr_q;
        sel_data  = write_data_q;
        pop       = 1'b0;
        bypass    = 1'b0;
        if (LdValid) begin
            sel_valid = 1'b1;
            sel_addr  = LdAddr;
            sel_data  = LdData;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_addr  = fifo_addr_q[rd_ptr_q];
            sel_data  = fifo_data_q[rd_ptr_q];
            pop       = 1'b1;
        end else if (AluValid) begin
            // FIFO is empty here, so the ALU result is accepted and goes straight out.
            sel_valid = 1'b1;
            sel_addr  = AluAddr;
            sel_data  = AluData;
            bypass    = 1'b1;
        end
    end

    assign push = alu_accept && !bypass;

    always_comb begin
        fifo_addr_d = fifo_addr_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        count_d     = count_q;
        if (push) begin
            fifo_addr_d[wr_ptr_q] = AluAddr;
            fifo_data_d[wr_ptr_q] = AluData;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        write_flag_d = sel_valid;
        write_addr_d = sel_addr;
        write_data_d = sel_data;
    end

    // The clear lands on the same edge the register file captures the data;
    // a simultaneous issue to that register is applied last so set wins.
    always_comb begin
        busy_d = busy_q;
        if (write_flag_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (IssueValid) begin
            busy_d[IssueAddr] = 1'b1;
        end
    end

    assign overflow_d = overflow_q || (AluValid && fifo_full);

    always_ff @(posedge gclk or negedge PowerOn_n) begin
        if (!PowerOn_n) begin
            fifo_addr_q  <= '{default: '0};
            fifo_data_q  <= '{default: '0};
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            write_flag_q <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            busy_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            write_flag_q <= write_flag_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
        end
    end

    assign WriteFlag   = write_flag_q;
    assign AddrWrite   = write_addr_q;
    assign Write       = write_data_q;
    assign OverflowErr = overflow_q;

    assign BusyA = busy_q[AddrReadA];
    assign BusyB = busy_q[AddrReadB];
    assign BusyC = busy_q[AddrReadC];

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: expected writes (cycle, address, data)
// are queued by the stimulus and checked by an independent write-port monitor.
`timescale 1ns/1ps
module tb_reg_write_arbiter;

    localparam int WW = 16;
    localparam int AW = 5;
    localparam int RN = 32;
    localparam int EW = 32 + AW + WW;

    logic          gclk;
    logic          PowerOn_n;
    logic          IssueValid;
    logic [AW-1:0] IssueAddr;
    logic          AluValid;
    logic [AW-1:0] AluAddr;
    logic [WW-1:0] AluData;
    logic          AluReady;
    logic          LdValid;
    logic [AW-1:0] LdAddr;
    logic [WW-1:0] LdData;
    logic [AW-1:0] AddrReadA, AddrReadB, AddrReadC;
    logic          BusyA, BusyB, BusyC;
    logic          WriteFlag;
    logic [AW-1:0] AddrWrite;
    logic [WW-1:0] Write;
    logic          OverflowErr;

    reg_write_arbiter #(.WORD_WIDTH(WW), .REG_ADDR_WIDTH(AW), .REG_NUM(RN)) dut (
        .gclk(gclk), .PowerOn_n(PowerOn_n),
        .IssueValid(IssueValid), .IssueAddr(IssueAddr),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
        .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData),
        .AddrReadA(AddrReadA), .AddrReadB(AddrReadB), .AddrReadC(AddrReadC),
        .BusyA(BusyA), .BusyB(BusyB), .BusyC(BusyC),
        .WriteFlag(WriteFlag), .AddrWrite(AddrWrite), .Write(Write),
        .OverflowErr(OverflowErr)
    );

    // Clock and cycle counter
    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    int unsigned cyc = 0;
    always @(posedge gclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic idle();
        IssueValid = 1'b0; IssueAddr = '0;
        AluValid   = 1'b0; AluAddr   = '0; AluData = '0;
        LdValid    = 1'b0; LdAddr    = '0; LdData  = '0;
    endtask

    task automatic drive_alu(input logic [AW-1:0] a, input logic [WW-1:0] d);
        AluValid = 1'b1; AluAddr = a; AluData = d;
    endtask

    task automatic drive_ld(input logic [AW-1:0] a, input logic [WW-1:0] d);
        LdValid = 1'b1; LdAddr = a; LdData = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        IssueValid = 1'b1; IssueAddr = a;
    endtask

    task automatic expect_write(input int unsigned c, input logic [AW-1:0] a, input logic [WW-1:0] d);
        exp_q.push_back({c, a, d});
    endtask

    // Write-port monitor
    logic [EW-1:0] mon_e;
    always @(negedge gclk) begin
        if (WriteFlag) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got r%0d=0x%0h at cycle %0d expected no write",
                         AddrWrite, Write, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_cycle", cyc, mon_e[EW-1 -: 32]);
                chk("write_addr", 32'(AddrWrite), 32'(mon_e[WW +: AW]));
                chk("write_data", 32'(Write), 32'(mon_e[WW-1:0]));
            end
        end
    end

    int unsigned c;

    initial begin
        idle();
        AddrReadA = '0; AddrReadB = '0; AddrReadC = '0;
        PowerOn_n = 1'b1;
        #2 PowerOn_n = 1'b0;
        #1;
        chk("rst_writeflag", 32'(WriteFlag), 0);
        chk("rst_addrwrite", 32'(AddrWrite), 0);
        chk("rst_write", 32'(Write), 0);
        chk("rst_overflow", 32'(OverflowErr), 0);
        chk("rst_aluready", 32'(AluReady), 1);
        chk("rst_busya", 32'(BusyA), 0);
        repeat (2) @(posedge gclk);
        #3 PowerOn_n = 1'b1;
        tick();

        // Bypass on an idle block
        c = cyc;
        drive_alu(5'd3, 16'h1234);
        expect_write(c + 1, 5'd3, 16'h1234);
        chk("bypass_ready", 32'(AluReady), 1);
        tick(); idle();
        chk("bypass_ready_after", 32'(AluReady), 1);
        tick(); tick();

        // Load and ALU collide: load first, ALU next cycle from the FIFO
        c = cyc;
        drive_ld(5'd5, 16'hAAAA);
        drive_alu(5'd6, 16'h5555);
        expect_write(c + 1, 5'd5, 16'hAAAA);
        expect_write(c + 2, 5'd6, 16'h5555);
        chk("conflict_ready0", 32'(AluReady), 1);
        tick(); idle();
        chk("conflict_ready1", 32'(AluReady), 1);
        tick(); tick();

        // Push and pop in the same cycle keep the FIFO at one entry
        c = cyc;
        drive_ld(5'd12, 16'h0C0C);
        drive_alu(5'd13, 16'h0D0D);
        expect_write(c + 1, 5'd12, 16'h0C0C);
        expect_write(c + 2, 5'd13, 16'h0D0D);
        tick(); idle();
        drive_alu(5'd14, 16'h0E0E);
        expect_write(c + 3, 5'd14, 16'h0E0E);
        chk("pushpop_ready1", 32'(AluReady), 1);
        tick(); idle();
        drive_alu(5'd15, 16'h0F0F);
        expect_write(c + 4, 5'd15, 16'h0F0F);
        chk("pushpop_ready2", 32'(AluReady), 1);
        tick(); idle();
        chk("pushpop_ready3", 32'(AluReady), 1);
        tick(); tick();

        // Loads hold the port for three cycles while the ALU offers r1..r3
        c = cyc;
        chk("ovf_clear_before", 32'(OverflowErr), 0);
        drive_ld(5'd10, 16'hA010); drive_alu(5'd1, 16'h0001);
        expect_write(c + 1, 5'd10, 16'hA010);
        chk("ovf_ready0", 32'(AluReady), 1);
        tick();
        drive_ld(5'd11, 16'hA011); drive_alu(5'd2, 16'h0002);
        expect_write(c + 2, 5'd11, 16'hA011);
        chk("ovf_ready1", 32'(AluReady), 1);
        tick();
        drive_ld(5'd12, 16'hA012); drive_alu(5'd3, 16'h0003);
        expect_write(c + 3, 5'd12, 16'hA012);
        chk("ovf_ready_full", 32'(AluReady), 0);
        chk("ovf_not_yet", 32'(OverflowErr), 0);
        tick(); idle();
        expect_write(c + 4, 5'd1, 16'h0001);
        expect_write(c + 5, 5'd2, 16'h0002);
        chk("ovf_set", 32'(OverflowErr), 1);
        tick(); tick(); tick();
        chk("ovf_sticky", 32'(OverflowErr), 1);

        // Scoreboard: set by issue, cleared one cycle after the write
        AddrReadA = 5'd7; AddrReadB = 5'd8; AddrReadC = 5'd2;
        chk("busy_a_initial", 32'(BusyA), 0);
        issue(5'd7);
        tick(); idle();
        chk("busy_a_set", 32'(BusyA), 1);
        chk("busy_b_other", 32'(BusyB), 0);
        c = cyc;
        drive_ld(5'd7, 16'h0777);
        expect_write(c + 1, 5'd7, 16'h0777);
        tick(); idle();
        chk("busy_a_no_bypass", 32'(BusyA), 1);
        tick();
        chk("busy_a_cleared", 32'(BusyA), 0);

        // Issue r7 on the clearing edge: set wins
        issue(5'd7);
        tick(); idle();
        c = cyc;
        drive_ld(5'd7, 16'h0778);
        expect_write(c + 1, 5'd7, 16'h0778);
        tick(); idle();
        issue(5'd7);
        tick(); idle();
        chk("busy_a_set_wins", 32'(BusyA), 1);
        issue(5'd2);
        tick(); idle();
        chk("busy_c_set", 32'(BusyC), 1);
        c = cyc;
        drive_ld(5'd7, 16'h0779);
        expect_write(c + 1, 5'd7, 16'h0779);
        tick(); idle();
        tick();
        chk("busy_a_cleared2", 32'(BusyA), 0);
        chk("busy_c_still", 32'(BusyC), 1);

        // Reset mid-operation with two buffered results and a busy bit
        AddrReadA = 5'd9;
        c = cyc;
        issue(5'd9);
        drive_ld(5'd20, 16'hB020); drive_alu(5'd21, 16'hC021);
        expect_write(c + 1, 5'd20, 16'hB020);
        tick(); idle();
        drive_ld(5'd22, 16'hB022); drive_alu(5'd23, 16'hC023);
        expect_write(c + 2, 5'd22, 16'hB022);
        tick(); idle();
        chk("rst_mid_full", 32'(AluReady), 0);
        chk("rst_mid_busy", 32'(BusyA), 1);
        #6;
        PowerOn_n = 1'b0;
        #1;
        chk("rst_mid_writeflag", 32'(WriteFlag), 0);
        chk("rst_mid_addrwrite", 32'(AddrWrite), 0);
        chk("rst_mid_write", 32'(Write), 0);
        chk("rst_mid_overflow", 32'(OverflowErr), 0);
        chk("rst_mid_aluready", 32'(AluReady), 1);
        chk("rst_mid_busya", 32'(BusyA), 0);
        PowerOn_n = 1'b1;
        tick();
        repeat (6) tick();
        chk("post_rst_busya", 32'(BusyA), 0);
        chk("post_rst_busyc", 32'(BusyC), 0);
        chk("post_rst_ready", 32'(AluReady), 1);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
